// File: rtl/half_array_collector_pkg.sv
// Shared constants and types for the interpolation half-array datapath
// (input mux, collector and controller all import these).
package half_array_collector_pkg;

    localparam int NUM_ROWS  = 8;
    localparam int LANES     = 15;
    localparam int PIXEL_W   = 8;
    localparam int ACC_W     = 16;
    localparam int SHIFT     = 6;
    localparam int ROW_W     = 4;
    localparam int ROW_SEL_W = $clog2(NUM_ROWS);
    localparam int ARR_W     = NUM_ROWS * LANES * PIXEL_W;

    localparam logic [1:0] FRAC_A   = 2'd0;
    localparam logic [1:0] FRAC_B   = 2'd1;
    localparam logic [1:0] FRAC_C   = 2'd2;
    localparam logic [1:0] FRAC_BAD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    typedef logic [LANES-1:0][PIXEL_W-1:0] pix_row_t;
    typedef logic [NUM_ROWS-1:0][LANES-1:0][PIXEL_W-1:0] half_arr_t;

endpackage

// File: rtl/pixel_norm_clip.sv
// One FIR lane result -> stored pixel: round-half-up, arithmetic shift,
// clip to the unsigned pixel range.
module pixel_norm_clip
    import half_array_collector_pkg::*;
(
    input  logic [ACC_W-1:0]   acc,
    output logic [PIXEL_W-1:0] pix
);

    localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'(1 << (SHIFT-1));
    localparam logic signed [ACC_W:0] PMAX = (ACC_W+1)'((1 << PIXEL_W) - 1);

    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] shr;

    // One extra bit so the rounding add cannot wrap at the positive limit.
    always_comb begin
        sum = $signed({acc[ACC_W-1], acc}) + RND;
        shr = sum >>> SHIFT;
        if (shr[ACC_W])
            pix = '0;
        else if (shr > PMAX)
            pix = '1;
        else
            pix = shr[PIXEL_W-1:0];
    end

endmodule

// File: rtl/half_array_collector.sv
// Collects normalized FIR rows into the A/B/C half-sample arrays read back
// by the input mux; owns the storage, row counter and done handshake.
module half_array_collector
    import half_array_collector_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [1:0]               frac_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*ACC_W-1:0]   in_row,
    output logic [ARR_W-1:0]         a_half_array,
    output logic [ARR_W-1:0]         b_half_array,
    output logic [ARR_W-1:0]         c_half_array,
    output logic [ROW_W-1:0]         row_idx,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    state_e         state;
    logic [1:0]     frac_q;
    pix_row_t       norm_row;
    half_arr_t      a_q, b_q, c_q;
    logic           accept;
    logic [NUM_ROWS-1:0] we_a, we_b, we_c;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        pixel_norm_clip u_norm (
            .acc (in_row[k*ACC_W +: ACC_W]),
            .pix (norm_row[k])
        );
    end

    assign accept = (state == ST_COLLECT) && in_valid && in_ready;

    always_comb begin
        we_a = '0;
        we_b = '0;
        we_c = '0;
        if (accept) begin
            case (frac_q)
                FRAC_A:  we_a[row_idx[ROW_SEL_W-1:0]] = 1'b1;
                FRAC_B:  we_b[row_idx[ROW_SEL_W-1:0]] = 1'b1;
                FRAC_C:  we_c[row_idx[ROW_SEL_W-1:0]] = 1'b1;
                default: ;
            endcase
        end
    end

    // Untouched rows keep their contents across passes.
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                a_q[r] <= '0;
                b_q[r] <= '0;
                c_q[r] <= '0;
            end else begin
                if (we_a[r]) a_q[r] <= norm_row;
                if (we_b[r]) b_q[r] <= norm_row;
                if (we_c[r]) c_q[r] <= norm_row;
            end
        end
    end

    assign a_half_array = a_q;
    assign b_half_array = b_q;
    assign c_half_array = c_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            frac_q   <= FRAC_A;
            row_idx  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (frac_sel == FRAC_BAD) begin
                            err <= 1'b1;
                        end else begin
                            frac_q   <= frac_sel;
                            row_idx  <= '0;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                            state    <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (accept) begin
                        row_idx <= row_idx + 1'b1;
                        if (row_idx == ROW_W'(NUM_ROWS-1)) begin
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    row_idx <= '0;
                    state   <= ST_IDLE;
                end
                default: begin
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    row_idx  <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_half_array_collector.sv
// Directed bench for half_array_collector: normalization table plus
// hand-written multi-cycle pass sequences.
module tb_half_array_collector;
    import half_array_collector_pkg::*;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [1:0]       frac_sel;
    logic             in_valid;
    logic             in_ready;
    logic [239:0]     in_row;
    logic [959:0]     a_half_array, b_half_array, c_half_array;
    logic [3:0]       row_idx;
    logic             busy, done, err;

    half_array_collector dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .frac_sel     (frac_sel),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_row       (in_row),
        .a_half_array (a_half_array),
        .b_half_array (b_half_array),
        .c_half_array (c_half_array),
        .row_idx      (row_idx),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clock = ~clock;

    int n_err = 0;
    int n_chk = 0;
    int done_cnt = 0;

    always @(negedge clock) if (done === 1'b1) done_cnt++;

    typedef struct {
        logic [15:0] x;
        logic [7:0]  px;
    } vec_t;
    vec_t tbl[8];

    logic [959:0] exp_a, exp_b, exp_c;

    task automatic chk_v(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_arr(input string nm, input logic [959:0] act, input logic [959:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [959:0] put_row(input logic [959:0] arr, input int r, input logic [7:0] b);
        logic [959:0] t;
        t = arr;
        t[r*120 +: 120] = {15{b}};
        return t;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_pass(input logic [1:0] f);
        start    = 1'b1;
        frac_sel = f;
        tick();
        start    = 1'b0;
    endtask

    // Drive a row and wait (bounded) for the accepting edge; in_valid stays high.
    task automatic send_row(input logic [15:0] x);
        int guard;
        in_row   = {15{x}};
        in_valid = 1'b1;
        guard    = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        if (guard == 20) begin
            n_chk++;
            n_err++;
            $display("FAIL send_row_timeout: in_ready=%b want 1", in_ready);
        end else begin
            tick();
        end
    endtask

    initial begin
        int d0;
        tbl[0] = '{16'hFFC0, 8'd0};    // -64
        tbl[1] = '{16'd31,   8'd0};
        tbl[2] = '{16'd32,   8'd1};
        tbl[3] = '{16'd20000, 8'd255};
        tbl[4] = '{16'h8000, 8'd0};    // -32768
        tbl[5] = '{16'd16351, 8'd255};
        tbl[6] = '{16'd6400, 8'd100};
        tbl[7] = '{16'd96,   8'd2};

        reset = 1'b0; start = 1'b0; frac_sel = 2'd0; in_valid = 1'b0; in_row = '0;
        exp_a = '0; exp_b = '0; exp_c = '0;
        tick(); tick();
        chk_arr("rst_a", a_half_array, '0);
        chk_arr("rst_b", b_half_array, '0);
        chk_arr("rst_c", c_half_array, '0);
        chk_v("rst_row_idx", 32'(row_idx), 0);
        chk_v("rst_flags", {28'd0, in_ready, busy, done, err}, 0);
        reset = 1'b1;
        tick();

        // Basic fill of A with back-to-back rows
        start_pass(FRAC_A);
        chk_v("fill_ready", {30'd0, in_ready, busy}, 3);
        chk_v("fill_row0", 32'(row_idx), 0);
        for (int r = 0; r < 8; r++) send_row(16'd6400);
        in_valid = 1'b0;
        exp_a = {120{8'd100}};
        chk_v("fill_done", 32'(done), 1);
        chk_v("fill_ready_low", 32'(in_ready), 0);
        chk_arr("fill_a", a_half_array, exp_a);
        chk_arr("fill_b", b_half_array, exp_b);
        chk_arr("fill_c", c_half_array, exp_c);
        tick();
        chk_v("fill_done_once", 32'(done), 0);
        chk_v("fill_row_idx_idle", 32'(row_idx), 0);
        chk_v("fill_done_cnt", 32'(done_cnt), 1);

        // in_valid held in IDLE must not transfer
        in_row = {15{16'd1000}};
        in_valid = 1'b1;
        tick(); tick();
        chk_v("idle_valid_row_idx", 32'(row_idx), 0);
        chk_arr("idle_valid_b", b_half_array, exp_b);
        in_valid = 1'b0;

        // Normalization table into B with a 1,0,0 valid pattern
        start_pass(FRAC_B);
        for (int r = 0; r < 8; r++) begin
            send_row(tbl[r].x);
            chk_v($sformatf("gap_idx_acc%0d", r), 32'(row_idx), 32'(r + 1));
            in_valid = 1'b0;
            if (r < 7) begin
                tick(); tick();
                chk_v($sformatf("gap_idx_hold%0d", r), 32'(row_idx), 32'(r + 1));
            end
        end
        chk_v("gap_done", 32'(done), 1);
        for (int r = 0; r < 8; r++) begin
            exp_b = put_row(exp_b, r, tbl[r].px);
            for (int k = 0; k < 15; k++)
                chk_v($sformatf("norm_r%0d_l%0d", r, k),
                      32'(b_half_array[r*120 + k*8 +: 8]), 32'(tbl[r].px));
        end
        chk_arr("gap_a_kept", a_half_array, exp_a);
        tick();
        chk_v("gap_done_cnt", 32'(done_cnt), 2);

        // Pass isolation: A = 10*r, then C = 200
        start_pass(FRAC_A);
        for (int r = 0; r < 8; r++) begin
            send_row(16'(640 * r));
            exp_a = put_row(exp_a, r, 8'(10 * r));
        end
        in_valid = 1'b0;
        tick();
        start_pass(FRAC_C);
        for (int r = 0; r < 8; r++) send_row(16'd12800);
        in_valid = 1'b0;
        exp_c = {120{8'd200}};
        chk_arr("iso_a", a_half_array, exp_a);
        chk_arr("iso_b", b_half_array, exp_b);
        chk_arr("iso_c", c_half_array, exp_c);
        tick();

        // Illegal start, then ignored start mid-COLLECT
        start_pass(FRAC_BAD);
        chk_v("bad_err", 32'(err), 1);
        chk_v("bad_idle", {30'd0, in_ready, busy}, 0);
        tick();
        chk_v("bad_stays_idle", {29'd0, in_ready, busy, err}, 1);
        start_pass(FRAC_B);
        for (int r = 0; r < 3; r++) send_row(16'd3200);
        in_valid = 1'b0;
        start    = 1'b1;
        frac_sel = FRAC_A;
        tick();
        start    = 1'b0;
        chk_v("midstart_row_idx", 32'(row_idx), 3);
        chk_v("midstart_busy", 32'(busy), 1);
        for (int r = 3; r < 8; r++) send_row(16'd3200);
        in_valid = 1'b0;
        exp_b = {120{8'd50}};
        chk_arr("midstart_b", b_half_array, exp_b);
        chk_arr("midstart_a", a_half_array, exp_a);
        chk_v("midstart_err_sticky", 32'(err), 1);
        tick();

        // Reset in the middle of a pass
        start_pass(FRAC_C);
        for (int r = 0; r < 4; r++) send_row(16'd6400);
        in_valid = 1'b0;
        d0 = done_cnt;
        reset = 1'b0;
        #1;
        chk_arr("mrst_a", a_half_array, '0);
        chk_arr("mrst_b", b_half_array, '0);
        chk_arr("mrst_c", c_half_array, '0);
        chk_v("mrst_row_idx", 32'(row_idx), 0);
        chk_v("mrst_flags", {28'd0, in_ready, busy, done, err}, 0);
        tick();
        reset = 1'b1;
        tick(); tick();
        chk_v("mrst_no_done", 32'(done_cnt), 32'(d0));
        start_pass(FRAC_A);
        for (int r = 0; r < 8; r++) send_row(16'd6400);
        in_valid = 1'b0;
        chk_v("mrst_pass_done", 32'(done), 1);
        chk_arr("mrst_pass_a", a_half_array, {120{8'd100}});
        chk_arr("mrst_pass_c", c_half_array, '0);
        tick();
        chk_v("mrst_done_cnt", 32'(done_cnt), 32'(d0 + 1));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule
